// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: left-normalizes an operand using an upstream leading-zero
// count and lowers its biased exponent by the same amount. When the exponent
// cannot absorb the full shift, the result is left denormal (exponent 0).
// Two-stage valid/ready pipeline, one beat per cycle.
//
// Optional feature: define LZC_CHECK_EN to recompute the leading-zero count
// locally and raise a sticky err flag on any disagreement with Z.
module lzc_norm_pipe #(
   parameter int WIDTH = 64,
   parameter int EXP_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         A,
   input  logic [$clog2(WIDTH):0]   Z,
   input  logic [EXP_W-1:0]         exp_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         M,
   output logic [EXP_W-1:0]         exp_out,
   output logic [$clog2(WIDTH)-1:0] shamt,
   output logic                     zero,
   output logic                     den,
   output logic                     err
);

   localparam int ZW   = $clog2(WIDTH) + 1;
   localparam int SW   = ZW - 1;
   // Common width for the unsigned count-vs-exponent compare.
   localparam int CMPW = (ZW > EXP_W) ? ZW : EXP_W;

   logic             s2_en_s;
   logic             in_fire_s;
   logic [ZW-1:0]    cnt_s;
   logic [SW-1:0]    shamt_d_s;
   logic [EXP_W-1:0] exp_d_s;
   logic             zero_d_s;
   logic             den_d_s;

   logic             s1_valid_r;
   logic [WIDTH-1:0] a_s1_r;
   logic [SW-1:0]    shamt_s1_r;
   logic [EXP_W-1:0] exp_s1_r;
   logic             zero_s1_r;
   logic             den_s1_r;

   // Stage 2 may load whenever its output slot is empty or being drained;
   // stage 1 may load whenever it is empty or moving into stage 2.
   assign s2_en_s   = ~out_valid | out_ready;
   assign in_ready  = ~s1_valid_r | s2_en_s;
   assign in_fire_s = in_valid & in_ready;

   // Effective shift count: an all-zero operand counts as a full-width shift.
   always_comb begin
      cnt_s = {1'b0, Z[ZW-2:0]};
      if (Z[ZW-1]) begin
         cnt_s = ZW'(WIDTH);
      end else begin
         cnt_s = {1'b0, Z[ZW-2:0]};
      end
   end

   // Pick zero / clamp / normal case for the incoming beat.
   always_comb begin
      shamt_d_s = {SW{1'b0}};
      exp_d_s   = {EXP_W{1'b0}};
      zero_d_s  = 1'b0;
      den_d_s   = 1'b0;
      if (Z[ZW-1]) begin
         zero_d_s = 1'b1;
      end else if (CMPW'(cnt_s) > CMPW'(exp_in)) begin
         // Exponent runs out first: shift only by exp_in, result is denormal.
         shamt_d_s = SW'(exp_in);
         den_d_s   = 1'b1;
      end else begin
         shamt_d_s = cnt_s[SW-1:0];
         exp_d_s   = exp_in - EXP_W'(cnt_s);
      end
   end

   // Stage 1 register: capture operand and shift decision on input transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         a_s1_r     <= {WIDTH{1'b0}};
         shamt_s1_r <= {SW{1'b0}};
         exp_s1_r   <= {EXP_W{1'b0}};
         zero_s1_r  <= 1'b0;
         den_s1_r   <= 1'b0;
      end else if (in_fire_s) begin
         s1_valid_r <= 1'b1;
         a_s1_r     <= A;
         shamt_s1_r <= shamt_d_s;
         exp_s1_r   <= exp_d_s;
         zero_s1_r  <= zero_d_s;
         den_s1_r   <= den_d_s;
      end else if (s2_en_s) begin
         s1_valid_r <= 1'b0;
      end
   end

   // Stage 2 register: perform the shift and present the result; holds on stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         M         <= {WIDTH{1'b0}};
         exp_out   <= {EXP_W{1'b0}};
         shamt     <= {SW{1'b0}};
         zero      <= 1'b0;
         den       <= 1'b0;
      end else if (s2_en_s) begin
         out_valid <= s1_valid_r;
         if (s1_valid_r) begin
            M       <= a_s1_r << shamt_s1_r;
            exp_out <= exp_s1_r;
            shamt   <= shamt_s1_r;
            zero    <= zero_s1_r;
            den     <= den_s1_r;
         end
      end
   end

`ifdef LZC_CHECK_EN
   // Reference leading-zero count by priority scan from the MSB.
   function automatic logic [SW-1:0] lzc_f(input logic [WIDTH-1:0] v);
      logic found;
      lzc_f = {SW{1'b0}};
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found && v[i]) begin
            found = 1'b1;
            lzc_f = SW'(WIDTH - 1 - i);
         end
      end
      return lzc_f;
   endfunction

   logic mismatch_s;

   // Compare the supplied count (and all-zero flag) against the local one.
   always_comb begin
      mismatch_s = 1'b0;
      if (A == {WIDTH{1'b0}}) begin
         mismatch_s = ~Z[ZW-1];
      end else begin
         mismatch_s = Z[ZW-1] | (Z[ZW-2:0] != lzc_f(A));
      end
   end

   // Sticky error flag, set by any accepted beat with a bad count.
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (in_fire_s && mismatch_s) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule
